// File: rtl/lcd_ctrl_gen_if.sv
// Host/memory-side signal bundle of the LCD controller: command strobe, IROM read port
// and IRAM write port with valid/ready backpressure.
interface lcd_ctrl_gen_if #(
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int DW = 8
);
  localparam int AW = XW + YW;

  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] irom_q;
  logic          irom_rd;
  logic [AW-1:0] irom_a;
  logic          iram_valid;
  logic          iram_ready;
  logic [DW-1:0] iram_d;
  logic [AW-1:0] iram_a;
  logic          busy;
  logic          done;

  modport master (
    output cmd, cmd_valid, irom_q, iram_ready,
    input  irom_rd, irom_a, iram_valid, iram_d, iram_a, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, irom_q, iram_ready,
    output irom_rd, irom_a, iram_valid, iram_d, iram_a, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_gen.sv
// Image display controller: loads an image from IROM, edits a 2x2 window around a movable
// operation point on host commands, and streams the image to IRAM with backpressure.
module lcd_ctrl_gen #(
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         reset,
  lcd_ctrl_gen_if.slave bus
);
  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;
  localparam logic [AW-1:0] LAST_A = AW'(N - 1);
  localparam logic [AW:0]   N_CNT  = (AW+1)'(N);
  localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
  localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};
  localparam logic [XW-1:0] X_MIN  = XW'(1);
  localparam logic [YW-1:0] Y_MIN  = YW'(1);
  localparam logic [XW-1:0] X_RST  = XW'(1 << (XW - 1));
  localparam logic [YW-1:0] Y_RST  = YW'(1 << (YW - 1));

  localparam logic [3:0] CMD_WRITE = 4'd0,  CMD_UP    = 4'd1,  CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3,  CMD_RIGHT = 4'd4,  CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6,  CMD_AVG   = 4'd7,  CMD_CCW   = 4'd8;
  localparam logic [3:0] CMD_CW    = 4'd9,  CMD_MIRX  = 4'd10, CMD_MIRY  = 4'd11;
  localparam logic [3:0] CMD_LOAD  = 4'd12;

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_CALC, S_WRITE} state_t;

  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input logic inc);
    if (inc) return (x == X_MAX) ? x : x + 1'b1;
    return (x == X_MIN) ? x : x - 1'b1;
  endfunction

  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input logic inc);
    if (inc) return (y == Y_MAX) ? y : y + 1'b1;
    return (y == Y_MIN) ? y : y - 1'b1;
  endfunction

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [DW-1:0] min4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, b, c, d);
    logic [DW+1:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[DW+1:2];
  endfunction

  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          irom_rd_q, irom_rd_d;
  logic [AW-1:0] irom_a_q, irom_a_d;
  logic [AW:0]   iss_q, iss_d;
  logic          iram_valid_q, iram_valid_d;
  logic [AW-1:0] iram_a_q, iram_a_d;
  logic [DW-1:0] iram_d_q, iram_d_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [DW-1:0] img_q [N];

  logic [XW-1:0] xm1;
  logic [YW-1:0] ym1;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DW-1:0] p_tl, p_tr, p_bl, p_br;
  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic [DW-1:0] v_max, v_min, v_avg;

  assign xm1  = x_q - 1'b1;
  assign ym1  = y_q - 1'b1;
  assign a_tl = {ym1, xm1};
  assign a_tr = {ym1, x_q};
  assign a_bl = {y_q, xm1};
  assign a_br = {y_q, x_q};
  assign p_tl = img_q[a_tl];
  assign p_tr = img_q[a_tr];
  assign p_bl = img_q[a_bl];
  assign p_br = img_q[a_br];
  assign v_max = max4(p_tl, p_tr, p_bl, p_br);
  assign v_min = min4(p_tl, p_tr, p_bl, p_br);
  assign v_avg = avg4(p_tl, p_tr, p_bl, p_br);

  always_comb begin
    n_tl = p_tl;
    n_tr = p_tr;
    n_bl = p_bl;
    n_br = p_br;
    case (cmd_q)
      CMD_MAX:  begin n_tl = v_max; n_tr = v_max; n_bl = v_max; n_br = v_max; end
      CMD_MIN:  begin n_tl = v_min; n_tr = v_min; n_bl = v_min; n_br = v_min; end
      CMD_AVG:  begin n_tl = v_avg; n_tr = v_avg; n_bl = v_avg; n_br = v_avg; end
      CMD_CCW:  begin n_tl = p_tr;  n_tr = p_br;  n_br = p_bl;  n_bl = p_tl;  end
      CMD_CW:   begin n_tl = p_bl;  n_bl = p_br;  n_br = p_tr;  n_tr = p_tl;  end
      CMD_MIRX: begin n_tl = p_bl;  n_bl = p_tl;  n_tr = p_br;  n_br = p_tr;  end
      CMD_MIRY: begin n_tl = p_tr;  n_tr = p_tl;  n_bl = p_br;  n_br = p_bl;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    irom_rd_d    = 1'b0;
    irom_a_d     = irom_a_q;
    iss_d        = iss_q;
    iram_valid_d = iram_valid_q;
    iram_a_d     = iram_a_q;
    iram_d_d     = iram_d_q;
    x_d          = x_q;
    y_d          = y_q;
    cmd_d        = cmd_q;
    unique case (state_q)
      S_LOAD: begin
        busy_d = 1'b1;
        if (iss_q != N_CNT) begin
          irom_rd_d = 1'b1;
          irom_a_d  = iss_q[AW-1:0];
          iss_d     = iss_q + 1'b1;
        end
        // The capture of the last address ends the load.
        if (irom_rd_q && irom_a_q == LAST_A) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.cmd_valid && !busy_q) begin
          cmd_d  = bus.cmd;
          busy_d = 1'b1;
          if (bus.cmd == CMD_WRITE) begin
            state_d      = S_WRITE;
            iram_valid_d = 1'b1;
            iram_a_d     = '0;
            iram_d_d     = img_q[0];
          end else if (bus.cmd == CMD_LOAD) begin
            state_d = S_LOAD;
            iss_d   = '0;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        case (cmd_q)
          CMD_UP:    y_d = step_y(y_q, 1'b0);
          CMD_DOWN:  y_d = step_y(y_q, 1'b1);
          CMD_LEFT:  x_d = step_x(x_q, 1'b0);
          CMD_RIGHT: x_d = step_x(x_q, 1'b1);
          default: ;
        endcase
      end
      S_WRITE: begin
        if (bus.iram_ready) begin
          if (iram_a_q == LAST_A) begin
            iram_valid_d = 1'b0;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            iram_a_d = iram_a_q + 1'b1;
            iram_d_d = img_q[iram_a_q + 1'b1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOAD;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      irom_rd_q    <= 1'b0;
      irom_a_q     <= '0;
      iss_q        <= '0;
      iram_valid_q <= 1'b0;
      iram_a_q     <= '0;
      iram_d_q     <= '0;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      irom_rd_q    <= irom_rd_d;
      irom_a_q     <= irom_a_d;
      iss_q        <= iss_d;
      iram_valid_q <= iram_valid_d;
      iram_a_q     <= iram_a_d;
      iram_d_q     <= iram_d_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cmd_q        <= cmd_d;
    end
  end

  // Image buffer carries data only, so it has no reset; non-window commands rewrite unchanged pixels.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && irom_rd_q) begin
      img_q[irom_a_q] <= bus.irom_q;
    end else if (state_q == S_CALC) begin
      img_q[a_tl] <= n_tl;
      img_q[a_tr] <= n_tr;
      img_q[a_bl] <= n_bl;
      img_q[a_br] <= n_br;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.irom_rd    = irom_rd_q;
  assign bus.irom_a     = irom_a_q;
  assign bus.iram_valid = iram_valid_q;
  assign bus.iram_a     = iram_a_q;
  assign bus.iram_d     = iram_d_q;
endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Scoreboard bench for lcd_ctrl_gen: an 8x8/8-bit instance and a 16x4/10-bit instance,
// each with a behavioural ROM and a reference image model feeding an expected-beat queue.
module tb_lcd_ctrl_gen;
  localparam int N = 64;

  typedef struct {
    int a;
    int d;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       iram_ready;
  logic [9:0] rom [2][N];

  lcd_ctrl_gen_if #(.XW(3), .YW(3), .DW(8))  bus_a ();
  lcd_ctrl_gen_if #(.XW(4), .YW(2), .DW(10)) bus_b ();

  lcd_ctrl_gen #(.XW(3), .YW(3), .DW(8))  dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  lcd_ctrl_gen #(.XW(4), .YW(2), .DW(10)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  assign bus_a.cmd        = cmd;
  assign bus_a.cmd_valid  = cmd_valid && !sel;
  assign bus_a.irom_q     = rom[0][bus_a.irom_a][7:0];
  assign bus_a.iram_ready = iram_ready;
  assign bus_b.cmd        = cmd;
  assign bus_b.cmd_valid  = cmd_valid && sel;
  assign bus_b.irom_q     = rom[1][bus_b.irom_a];
  assign bus_b.iram_ready = iram_ready;

  logic       busy, done, ivld, irom_rd;
  logic [5:0] ia, irom_a;
  logic [9:0] idat;
  assign busy    = sel ? bus_b.busy       : bus_a.busy;
  assign done    = sel ? bus_b.done       : bus_a.done;
  assign ivld    = sel ? bus_b.iram_valid : bus_a.iram_valid;
  assign ia      = sel ? bus_b.iram_a     : bus_a.iram_a;
  assign idat    = sel ? bus_b.iram_d     : {2'b00, bus_a.iram_d};
  assign irom_rd = sel ? bus_b.irom_rd    : bus_a.irom_rd;
  assign irom_a  = sel ? bus_b.irom_a     : bus_a.irom_a;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [9:0] mimg [2][N];
  int         mx [2];
  int         my [2];
  beat_t      sbq [$];
  beat_t      mon_e;
  logic [9:0] got [N];
  int         beat_cnt = 0;
  int         done_cnt = 0;
  logic       stall_pend = 1'b0;
  logic [5:0] st_a;
  logic [9:0] st_d;
  int         rdy_mode = 0;
  int         ph = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int wd(input int s);
    return (s != 0) ? 16 : 8;
  endfunction

  function automatic int ht(input int s);
    return (s != 0) ? 4 : 8;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mx[s] = wd(s) / 2;
      my[s] = ht(s) / 2;
      for (int a = 0; a < N; a++) mimg[s][a] = rom[s][a];
    end
  endtask

  task automatic model_cmd(input int s, input logic [3:0] c);
    int w, tl, tr, bl, br, sum;
    logic [9:0] vtl, vtr, vbl, vbr, m;
    w  = wd(s);
    tl = (my[s] - 1) * w + mx[s] - 1;
    tr = tl + 1;
    bl = tl + w;
    br = bl + 1;
    vtl = mimg[s][tl]; vtr = mimg[s][tr]; vbl = mimg[s][bl]; vbr = mimg[s][br];
    case (c)
      4'd1: if (my[s] > 1) my[s]--;
      4'd2: if (my[s] < ht(s) - 1) my[s]++;
      4'd3: if (mx[s] > 1) mx[s]--;
      4'd4: if (mx[s] < w - 1) mx[s]++;
      4'd5, 4'd6, 4'd7: begin
        m = vtl;
        if (c == 4'd5) begin
          if (vtr > m) m = vtr;
          if (vbl > m) m = vbl;
          if (vbr > m) m = vbr;
        end else if (c == 4'd6) begin
          if (vtr < m) m = vtr;
          if (vbl < m) m = vbl;
          if (vbr < m) m = vbr;
        end else begin
          sum = vtl + vtr + vbl + vbr;
          m = 10'(sum / 4);
        end
        mimg[s][tl] = m; mimg[s][tr] = m; mimg[s][bl] = m; mimg[s][br] = m;
      end
      4'd8:  begin mimg[s][tl] = vtr; mimg[s][tr] = vbr; mimg[s][br] = vbl; mimg[s][bl] = vtl; end
      4'd9:  begin mimg[s][tl] = vbl; mimg[s][bl] = vbr; mimg[s][br] = vtr; mimg[s][tr] = vtl; end
      4'd10: begin mimg[s][tl] = vbl; mimg[s][bl] = vtl; mimg[s][tr] = vbr; mimg[s][br] = vtr; end
      4'd11: begin mimg[s][tl] = vtr; mimg[s][tr] = vtl; mimg[s][bl] = vbr; mimg[s][br] = vbl; end
      4'd12: for (int a = 0; a < N; a++) mimg[s][a] = rom[s][a];
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("wait_idle", busy, 0);
  endtask

  // hold > 1 keeps cmd_valid up into the busy cycle, where it must be ignored.
  task automatic send_cmd(input logic [3:0] c, input int hold = 1);
    int s;
    s = sel ? 1 : 0;
    wait_idle();
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy_after_accept", busy, 1);
    model_cmd(s, c);
    if (c == 4'd0)
      for (int a = 0; a < N; a++) sbq.push_back('{a, int'(mimg[s][a])});
    if (hold > 1) begin
      repeat (hold - 1) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_write();
    int bb, bd, t;
    bb = beat_cnt;
    bd = done_cnt;
    t = 0;
    send_cmd(4'd0);
    while (done_cnt == bd && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_once", done_cnt - bd, 1);
    check_eq("beat_count", beat_cnt - bb, N);
    check_eq("idle_after_write", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_irom_rd", irom_rd, 0);
    check_eq("rst_irom_a", irom_a, 0);
    check_eq("rst_iram_valid", ivld, 0);
    check_eq("rst_iram_d", idat, 0);
    check_eq("rst_iram_a", ia, 0);
    check_eq("rst_done", done, 0);
    sbq.delete();
    stall_pend = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    iram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) iram_ready = 1'b1;
      else begin
        iram_ready = (ph % 3 == 0);
        ph++;
      end
    end
  end

  // Beats are judged at the negedge preceding the edge that accepts them.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (stall_pend) begin
          check_eq("stall_valid", ivld, 1);
          check_eq("stall_addr", ia, st_a);
          check_eq("stall_data", idat, st_d);
          stall_pend = 1'b0;
        end
        if (ivld) begin
          if (iram_ready) begin
            if (sbq.size() > 0) mon_e = sbq.pop_front();
            else mon_e = '{-1, -1};
            check_eq("beat_addr", ia, mon_e.a);
            check_eq("beat_data", idat, mon_e.d);
            got[ia] = idat;
            beat_cnt++;
          end else begin
            stall_pend = 1'b1;
            st_a = ia;
            st_d = idat;
          end
        end
        if (done) begin
          done_cnt++;
          check_eq("done_sb_empty", sbq.size(), 0);
          check_eq("busy_at_done", busy, 0);
          check_eq("valid_at_done", ivld, 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb, bd, t;
    logic [3:0] seq [16];
    logic [3:0] rc;
    sel = 1'b0;
    cmd = 4'd0;
    cmd_valid = 1'b0;
    for (int a = 0; a < N; a++) begin
      rom[0][a] = 10'(a);
      rom[1][a] = 10'(a);
    end
    repeat (2) @(negedge clk);

    // T1: load timing and a plain full write
    do_reset();
    repeat (N) @(posedge clk);
    @(negedge clk);
    check_eq("load_busy_at_N", busy, 1);
    check_eq("load_last_addr", irom_a, N - 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("load_busy_at_N1", busy, 0);
    do_write();
    check_eq("t1_pix0", got[0], 0);
    check_eq("t1_pix63", got[63], 63);

    // T2: clamp at the top-left corner, then MAX
    rom[0][0] = 10'd3; rom[0][1] = 10'd7; rom[0][8] = 10'd200; rom[0][9] = 10'd9;
    do_reset();
    send_cmd(4'd3, 2);
    repeat (4) send_cmd(4'd3);
    repeat (5) send_cmd(4'd1);
    send_cmd(4'd5);
    do_write();
    check_eq("t2_tl", got[0], 200);
    check_eq("t2_tr", got[1], 200);
    check_eq("t2_bl", got[8], 200);
    check_eq("t2_br", got[9], 200);
    check_eq("t2_untouched", got[2], 2);

    // T3: AVG without overflow, CW then CCW
    rom[0][0] = 10'd255; rom[0][1] = 10'd255; rom[0][8] = 10'd255; rom[0][9] = 10'd254;
    send_cmd(4'd12);
    send_cmd(4'd7);
    do_write();
    check_eq("t3_avg_tl", got[0], 254);
    check_eq("t3_avg_br", got[9], 254);
    rom[0][0] = 10'd1; rom[0][1] = 10'd2; rom[0][8] = 10'd3; rom[0][9] = 10'd4;
    send_cmd(4'd12);
    send_cmd(4'd9);
    do_write();
    check_eq("t3_cw_tl", got[0], 3);
    check_eq("t3_cw_tr", got[1], 1);
    check_eq("t3_cw_bl", got[8], 4);
    check_eq("t3_cw_br", got[9], 2);
    send_cmd(4'd8);
    do_write();
    check_eq("t3_ccw_tl", got[0], 1);
    check_eq("t3_ccw_tr", got[1], 2);
    check_eq("t3_ccw_bl", got[8], 3);
    check_eq("t3_ccw_br", got[9], 4);

    // T4: mixed command stream, then writes under a stalling sink
    seq = '{4'd4, 4'd4, 4'd2, 4'd10, 4'd11, 4'd6, 4'd4, 4'd2,
            4'd2, 4'd5, 4'd7, 4'd9, 4'd8, 4'd1, 4'd13, 4'd11};
    for (int i = 0; i < 16; i++) send_cmd(seq[i]);
    for (int i = 0; i < 12; i++) begin
      rc = 4'($urandom_range(1, 15));
      if (rc == 4'd12) rc = 4'd14;
      send_cmd(rc);
    end
    rdy_mode = 1;
    do_write();
    do_write();
    rdy_mode = 0;

    // T5: reset in the middle of a write
    for (int a = 0; a < N; a++) rom[0][a] = 10'(a);
    send_cmd(4'd12);
    bb = beat_cnt;
    bd = done_cnt;
    t = 0;
    send_cmd(4'd0);
    while (beat_cnt < bb + 20 && t < 500) begin
      @(negedge clk);
      t++;
    end
    #1;
    do_reset();
    check_eq("t5_no_done", done_cnt - bd, 0);
    @(posedge clk);
    #1;
    check_eq("t5_irom_rd", irom_rd, 1);
    check_eq("t5_irom_a", irom_a, 0);
    send_cmd(4'd5);
    do_write();
    check_eq("t5_op_tl", got[27], 36);
    check_eq("t5_op_br", got[36], 36);

    // T6: 16x4 10-bit instance: clamps at the far corner, reload keeps the op point
    wait_idle();
    sel = 1'b1;
    repeat (20) send_cmd(4'd4);
    repeat (5) send_cmd(4'd2);
    for (int a = 0; a < N; a++) rom[1][a] = 10'(1023 - a);
    send_cmd(4'd12);
    send_cmd(4'd5);
    do_write();
    check_eq("t6_br", got[63], 977);
    check_eq("t6_tl", got[46], 977);
    check_eq("t6_left_of_win", got[45], 978);
    check_eq("t6_pix0", got[0], 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
